inst_fetch_unit: RTL and testbench

- Front-end producer of the instruction stream that the control unit decodes.
- Holds the fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words in a small FIFO and presents {pc, instruction, OPcode, Func} to decode with a valid/ready handshake.
- Accepts jump/branch redirects from execute, flushing the buffer and discarding any in-flight response.

---
 rtl/inst_fetch_unit_pkg.sv | 30 +++
 rtl/inst_fifo.sv | 68 ++++++
 rtl/inst_fetch_unit.sv | 116 +++++++++++
 tb/tb_inst_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end and the control unit.
// Holds the fetch state encodings, the default reset PC, the OPcode/Func
// bit positions of an instruction word and the buffered fetch entry layout.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,  // no request outstanding
    ST_WAIT    = 2'd1,  // one request outstanding, response will be kept
    ST_DISCARD = 2'd2   // one request outstanding, response will be dropped
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  // One buffered instruction: the address it was fetched from and the word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are cleared.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Purpose: synchronous FIFO of {pc, word} fetch entries, flush has priority over push.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
// Ports: clk_i/reset_n_i clock and async active-low reset; push_i/push_dat_i write;
//        pop_i removes the head; flush_i empties; count_o/empty_o/full_o status;
//        head_o is the oldest entry, or zero while empty.
module inst_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] count_o,
  output logic         empty_o,
  output logic         full_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Purpose: fetch PC, single-outstanding instruction memory reads, buffered decode feed.
// Latency: request one cycle after entering FETCH; instruction valid the cycle after rvalid.
// Backpressure: stops issuing while the buffer (including the in-flight slot) is full.
// Ports: clk/reset_n; imem_req/imem_addr/imem_rvalid/imem_rdata to instruction memory;
//        inst_valid/inst_ready/inst_word/inst_pc/inst_opcode/inst_func to decode;
//        redirect_valid/redirect_pc from execute for jumps and taken branches.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic [5:0]  inst_opcode,
  output logic [5:0]  inst_func,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          imem_req_q, imem_req_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  logic [31:0]   redir_target;

  assign redir_target = align_word(redirect_pc);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;
    fifo_push   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_target;
        end else if (fifo_count < CW'(FIFO_DEPTH)) begin
          // The free slot is reserved now; only pops change count until the
          // response returns, so the later push always finds room.
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc_q;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_target;
          state_d    = imem_rvalid ? ST_FETCH : ST_DISCARD;
        end else if (imem_rvalid) begin
          fifo_push  = !fifo_full;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) fetch_pc_d = redir_target;
        if (imem_rvalid)    state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // A redirect flushes the buffer, so a same-cycle pop is irrelevant.
  assign fifo_pop = inst_valid && inst_ready && !redirect_valid;

  inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .push_i     (fifo_push),
    .push_dat_i ('{pc: fetch_pc_q, word: imem_rdata}),
    .pop_i      (fifo_pop),
    .flush_i    (redirect_valid),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .head_o     (fifo_head)
  );

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign inst_valid  = !fifo_empty;
  assign inst_word   = fifo_head.word;
  assign inst_pc     = fifo_head.pc;
  assign inst_opcode = fifo_head.word[OPCODE_MSB:OPCODE_LSB];
  assign inst_func   = fifo_head.word[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by a randomized run.
// A memory responder with configurable latency and a transaction-level model
// (expected request address, expected buffered instruction queue) run every cycle.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_word, inst_pc;
  logic [5:0]  inst_opcode, inst_func;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_word(inst_word), .inst_pc(inst_pc),
    .inst_opcode(inst_opcode), .inst_func(inst_func),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents: any deterministic word per address; 0x3000 holds 0x2008_0005.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a - RST_PC) * 32'h9E37_79B9 + 32'h2008_0005;
  endfunction

  // Model and environment state.
  logic [63:0] exp_q[$];
  bit          pend_active, pend_kept;
  int          pend_cnt;
  logic [31:0] pend_dut_addr, pend_pc, next_req_pc;
  int          cyc, rv_count, first_valid_cyc;
  logic [5:0]  first_opc;
  logic [31:0] first_pc;
  int          req_cyc[$], rv_cyc[$], pop_cyc[$];
  logic [31:0] req_addr[$], deliv_pc[$];
  int          lat_min = 1, lat_max = 1;
  bit          redir_req, rand_mode, ready_next;
  logic [31:0] redir_target;
  int          redir_at_rv;

  function automatic logic [31:0] ga(input int i);
    return (i < req_addr.size()) ? req_addr[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int gc(input int i);
    return (i < req_cyc.size()) ? req_cyc[i] : -1;
  endfunction
  function automatic int grv(input int i);
    return (i < rv_cyc.size()) ? rv_cyc[i] : -1;
  endfunction

  // One clock cycle: check outputs, act as memory, drive decode and redirect.
  task automatic cycle();
    logic [63:0] hd;
    bit rv_now, rv_kept, do_redir;
    logic [31:0] rv_pc;
    rv_kept = 1'b0;
    rv_pc = '0;
    @(negedge clk);
    cyc++;
    chk("inst_valid", inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      hd = exp_q[0];
      chk("inst_pc", inst_pc, hd[63:32]);
      chk("inst_word", inst_word, hd[31:0]);
      chk("inst_opcode", inst_opcode, hd[31:26]);
      chk("inst_func", inst_func, hd[5:0]);
    end else begin
      chk("empty_pc", inst_pc, 0);
      chk("empty_word", inst_word, 0);
    end
    if (inst_valid && first_valid_cyc < 0) begin
      first_valid_cyc = cyc;
      first_opc = inst_opcode;
      first_pc = inst_pc;
    end
    // Memory responder.
    rv_now = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    if (pend_active) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rv_now = 1'b1;
        rv_kept = pend_kept;
        rv_pc = pend_pc;
        imem_rvalid = 1'b1;
        imem_rdata = memw(pend_dut_addr);
        pend_active = 1'b0;
        rv_count++;
        rv_cyc.push_back(cyc);
      end
    end
    if (imem_req) begin
      chk("one_outstanding", pend_active, 0);
      chk("space_reserved", exp_q.size() < DEPTH, 1);
      chk("req_addr", imem_addr, next_req_pc);
      req_cyc.push_back(cyc);
      req_addr.push_back(imem_addr);
      pend_active = 1'b1;
      pend_kept = 1'b1;
      pend_cnt = $urandom_range(lat_min, lat_max);
      pend_dut_addr = imem_addr;
      pend_pc = next_req_pc;
      next_req_pc = next_req_pc + 32'd4;
    end
    // Decode side and redirects.
    do_redir = redir_req || (redir_at_rv != 0 && rv_now && rv_count == redir_at_rv);
    if (rand_mode) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        do_redir = 1'b1;
        redir_target = $urandom;
      end
    end else begin
      inst_ready = ready_next;
    end
    redirect_valid = do_redir;
    redirect_pc = redir_target;
    if (do_redir) begin
      exp_q.delete();
      pend_kept = 1'b0;
      next_req_pc = redir_target & ~32'd3;
      redir_req = 1'b0;
      redir_at_rv = 0;
    end else begin
      if (inst_valid && inst_ready) begin
        deliv_pc.push_back(inst_pc);
        pop_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (rv_now && rv_kept) exp_q.push_back({rv_pc, memw(rv_pc)});
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_word", inst_word, 0);
    chk("rst_opcode", inst_opcode, 0);
    chk("rst_func", inst_func, 0);
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    ready_next = 1'b0;
    exp_q.delete();
    req_cyc.delete(); req_addr.delete(); rv_cyc.delete();
    pop_cyc.delete(); deliv_pc.delete();
    pend_active = 1'b0;
    pend_kept = 1'b0;
    next_req_pc = RST_PC;
    rv_count = 0;
    redir_req = 1'b0;
    redir_at_rv = 0;
    first_valid_cyc = -1;
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_reqs(input string tag, input int n);
    int budget;
    budget = 0;
    while (req_cyc.size() < n && budget < 60) begin
      cycle();
      budget++;
    end
    chk(tag, req_cyc.size() >= n, 1);
  endtask

  initial begin
    int base;
    logic [31:0] held_pc, held_word;

    // Basic flow at latency 1.
    apply_reset();
    ready_next = 1'b1;
    lat_min = 1; lat_max = 1;
    wait_reqs("t1_timeout", 2);
    chk("t1_first_req_cyc", gc(0), 1);
    chk("t1_first_addr", ga(0), 32'h0000_3000);
    chk("t1_valid_cyc", first_valid_cyc, grv(0) + 1);
    chk("t1_opcode", first_opc, 6'b001000);
    chk("t1_pc", first_pc, 32'h0000_3000);
    chk("t1_second_addr", ga(1), 32'h0000_3004);
    chk("t1_issue_after_rv", gc(1) > grv(0), 1);

    // Decode stalled: buffer fills and fetching stops.
    apply_reset();
    ready_next = 1'b0;
    repeat (4) cycle();
    held_pc = inst_pc;
    held_word = inst_word;
    repeat (8) cycle();
    chk("t2_nreq", req_cyc.size(), 2);
    chk("t2_addr0", ga(0), 32'h0000_3000);
    chk("t2_addr1", ga(1), 32'h0000_3004);
    chk("t2_stable_pc", inst_pc, held_pc);
    chk("t2_stable_word", inst_word, held_word);
    ready_next = 1'b1;
    wait_reqs("t2_timeout", 3);
    chk("t2_req_after_pop", (pop_cyc.size() != 0) && (gc(2) > pop_cyc[0]), 1);
    chk("t2_addr2", ga(2), 32'h0000_3008);

    // Redirect while a latency-3 request is outstanding.
    apply_reset();
    ready_next = 1'b1;
    lat_min = 3; lat_max = 3;
    wait_reqs("t3_timeout_a", 1);
    redir_req = 1'b1;
    redir_target = 32'h0000_3100;
    cycle();
    wait_reqs("t3_timeout_b", 2);
    chk("t3_redir_addr", ga(1), 32'h0000_3100);
    chk("t3_discard_waits", gc(1) > grv(0), 1);
    repeat (6) cycle();
    chk("t3_first_deliv", (deliv_pc.size() != 0) ? deliv_pc[0] : 32'hxxxx_xxxx, 32'h0000_3100);

    // Redirect coincident with the second response, buffer holding one entry.
    apply_reset();
    ready_next = 1'b0;
    lat_min = 2; lat_max = 2;
    redir_at_rv = 2;
    redir_target = 32'h0000_3203;
    wait_reqs("t4_timeout_a", 2);
    repeat (3) cycle();
    chk("t4_rv_seen", rv_count, 2);
    chk("t4_flushed", inst_valid, 0);
    ready_next = 1'b1;
    wait_reqs("t4_timeout_b", 3);
    chk("t4_redir_addr", ga(2), 32'h0000_3200);

    // Reset while waiting with one buffered instruction.
    apply_reset();
    ready_next = 1'b0;
    lat_min = 3; lat_max = 3;
    wait_reqs("t5_timeout_a", 2);
    chk("t5_buffered", inst_valid, 1);
    apply_reset();
    ready_next = 1'b1;
    lat_min = 1; lat_max = 1;
    wait_reqs("t5_timeout_b", 1);
    chk("t5_restart_addr", ga(0), 32'h0000_3000);

    // Address wrap at the top of memory.
    redir_req = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    cycle();
    base = req_cyc.size();
    wait_reqs("t6_timeout", base + 2);
    chk("t6_addr_top", ga(base), 32'hFFFF_FFFC);
    chk("t6_addr_wrap", ga(base + 1), 32'h0000_0000);

    // Randomized traffic against the model.
    apply_reset();
    lat_min = 1; lat_max = 4;
    rand_mode = 1'b1;
    repeat (3000) cycle();
    rand_mode = 1'b0;
    chk("rand_progress", deliv_pc.size() > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
